// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter, 4 grants per cycle; optional stat_denied counter via WB_ARB_STATS_EN
module wb_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      wb_stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wb_valid1,
    output logic                      wb_valid2,
    output logic                      wb_valid3,
    output logic                      wb_valid4,
    output logic [TAG_W-1:0]          wb_idx1,
    output logic [TAG_W-1:0]          wb_idx2,
    output logic [TAG_W-1:0]          wb_idx3,
    output logic [TAG_W-1:0]          wb_idx4,
    output logic [DATA_W-1:0]         wb_value1,
    output logic [DATA_W-1:0]         wb_value2,
    output logic [DATA_W-1:0]         wb_value3,
    output logic [DATA_W-1:0]         wb_value4
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]               stat_denied
`endif
);

    localparam int NPORT = 4;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]  rr_ptr;
    logic              block;
    logic [NUM_REQ-1:0] grant;
    logic [2:0]        n_grant;
    logic [PTR_W-1:0]  last_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W:0]    sum;

    logic              slot_use  [NPORT];
    logic [PTR_W-1:0]  slot_src  [NPORT];
    logic [TAG_W-1:0]  slot_tag  [NPORT];
    logic [DATA_W-1:0] slot_data [NPORT];

    logic              port_valid [NPORT];
    logic [TAG_W-1:0]  port_idx   [NPORT];
    logic [DATA_W-1:0] port_value [NPORT];

    // Grants depend only on inputs and rr_ptr, never on the registered wb_* outputs.
    assign block = flush | wb_stall | ~reset_n;

    // Circular scan from rr_ptr collecting the first four valid requesters in order.
    always_comb begin
        grant    = '0;
        n_grant  = '0;
        last_idx = rr_ptr;
        sum      = '0;
        idx      = '0;
        for (int p = 0; p < NPORT; p++) begin
            slot_use[p] = 1'b0;
            slot_src[p] = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[PTR_W-1:0];
            if (!block && req_valid[idx] && (n_grant < 3'd4)) begin
                grant[idx]                = 1'b1;
                slot_use[n_grant[1:0]]    = 1'b1;
                slot_src[n_grant[1:0]]    = idx;
                last_idx                  = idx;
                n_grant                   = n_grant + 3'd1;
            end
        end
        for (int p = 0; p < NPORT; p++) begin
            slot_tag[p]  = req_tag[int'(slot_src[p]) * TAG_W +: TAG_W];
            slot_data[p] = req_data[int'(slot_src[p]) * DATA_W +: DATA_W];
        end
    end

    assign req_ready = grant;
    assign next_ptr  = (last_idx == LAST_REQ) ? '0 : last_idx + 1'b1;

    // Writeback port registers and round-robin pointer; flush beats stall beats grants.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            for (int p = 0; p < NPORT; p++) begin
                port_valid[p] <= 1'b0;
                port_idx[p]   <= '1;
                port_value[p] <= '0;
            end
        end else if (flush) begin
            rr_ptr <= '0;
            for (int p = 0; p < NPORT; p++) begin
                port_valid[p] <= 1'b0;
                port_idx[p]   <= '1;
                port_value[p] <= '0;
            end
        end else if (wb_stall) begin
            for (int p = 0; p < NPORT; p++) begin
                port_valid[p] <= 1'b0;
                port_idx[p]   <= '1;
                port_value[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                port_valid[p] <= slot_use[p];
                port_idx[p]   <= slot_use[p] ? slot_tag[p] : '1;
                port_value[p] <= slot_use[p] ? slot_data[p] : '0;
            end
            if (n_grant != 3'd0) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    assign wb_valid1 = port_valid[0];
    assign wb_valid2 = port_valid[1];
    assign wb_valid3 = port_valid[2];
    assign wb_valid4 = port_valid[3];
    assign wb_idx1   = port_idx[0];
    assign wb_idx2   = port_idx[1];
    assign wb_idx3   = port_idx[2];
    assign wb_idx4   = port_idx[3];
    assign wb_value1 = port_value[0];
    assign wb_value2 = port_value[1];
    assign wb_value3 = port_value[2];
    assign wb_value4 = port_value[3];

`ifdef WB_ARB_STATS_EN
    logic any_denied;
    assign any_denied = |(req_valid & ~grant);

    // Saturating count of cycles where some valid requester went ungranted (flush cycles excluded).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_denied <= '0;
        end else if (!flush && any_denied && (stat_denied != 16'hFFFF)) begin
            stat_denied <= stat_denied + 16'd1;
        end
    end
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- NUM_REQ, 6, number of functional-unit requesters (legal range 4..8).
- TAG_W, 6, physical-destination tag width.
- DATA_W, 32, result width.

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, input, 1, clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- flush, input, 1, pipeline flush; discards in-flight arbitration.
- wb_stall, input, 1, ROB cannot accept writebacks this cycle.
- req_valid, input, NUM_REQ, per-requester result valid.
- req_tag, input, NUM_REQ*TAG_W, per-requester destination tag; requester i occupies bits [i*TAG_W +: TAG_W].
- req_data, input, NUM_REQ*DATA_W, per-requester result; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready, output, NUM_REQ, per-requester grant (combinational).
- wb_valid1..wb_valid4, output, 1 each, registered writeback port valid.
- wb_idx1..wb_idx4, output, TAG_W each, registered writeback tag.
- wb_value1..wb_value4, output, DATA_W each, registered writeback value.

Function
REQ-003 Each cycle, requesters SHALL be scanned circularly starting at rr_ptr, and the first up-to-4 requesters with req_valid=1 SHALL be granted.
REQ-004 req_ready[i] SHALL be 1 exactly when requester i is granted in the current cycle. A transfer occurs when req_valid[i] && req_ready[i].
REQ-005 No requester SHALL be granted while flush=1 or wb_stall=1; in that case all req_ready bits SHALL be 0.
REQ-006 Grants SHALL map to output ports in scan order: the 1st grant to port 1, the 2nd to port 2, and so on.
REQ-007 Ports SHALL be filled contiguously from port 1; unused ports SHALL have wb_validk=0.
REQ-008 On the edge after a grant, the registered outputs SHALL carry that grant's tag and data. Latency is exactly 1 cycle.
REQ-009 For a port with wb_validk=0, wb_idxk SHALL read all ones and wb_valuek SHALL read 0.
REQ-010 The pointer SHALL update as follows:
- If at least one grant occurred, rr_ptr SHALL become (index of last granted requester + 1) mod NUM_REQ.
- Otherwise rr_ptr SHALL hold.
REQ-011 Wrap-around: a scan from rr_ptr=NUM_REQ-1 SHALL continue at index 0 and SHALL visit each requester at most once.
REQ-012 Fairness: a requester holding req_valid=1 continuously, with wb_stall=0 and flush=0, SHALL be granted within ceil(NUM_REQ/4) cycles.
REQ-013 flush=1 SHALL clear all wb_validk on the next edge and reset rr_ptr to 0. flush SHALL take priority over wb_stall and over pending requests.
REQ-014 wb_stall=1 without flush SHALL clear all wb_validk on the next edge and hold rr_ptr.
REQ-015 Duplicate tags across requesters SHALL be forwarded unchanged; the arbiter performs no tag checking.
REQ-016 The block SHALL contain no combinational path from the wb_* outputs back to req_ready.

Reset
REQ-017 While reset_n=0, the block SHALL asynchronously force:
- rr_ptr=0
- all wb_validk=0, wb_idxk all ones, wb_valuek=0
- statistics state (if compiled in) to 0
REQ-018 req_ready SHALL be 0 while reset_n=0.
REQ-019 A reset asserted mid-operation SHALL discard registered grants; granted data is not replayed after reset.

Configuration
REQ-020 With macro WB_ARB_STATS_EN defined, the block SHALL add an output port stat_denied (16 bits).
- stat_denied is a saturating count of cycles in which at least one requester had req_valid=1 and req_ready=0.
- It SHALL count while flush=0, including stall cycles.
- It SHALL stick at 16'hFFFF once saturated.
REQ-021 Without WB_ARB_STATS_EN, neither the stat_denied port nor the counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-022 Case 1 -- reset, single requester:
- Stimulus: after reset, req_valid=6'b000100, req_tag[2]=6'd17, req_data[2]=32'hDEAD0001.
- Response: req_ready=6'b000100 the same cycle; next cycle wb_valid1=1, wb_idx1=17, wb_value1=32'hDEAD0001, wb_valid2..4=0; rr_ptr becomes 3.
REQ-023 Case 2 -- all six valid, rr_ptr=0:
- Stimulus: req_valid=6'b111111 held for two cycles.
- Response: cycle 1 grants 0,1,2,3 on ports 1..4, rr_ptr becomes 4; cycle 2 grants 4,5,0,1 on ports 1..4, rr_ptr becomes 2.
REQ-024 Case 3 -- wrap-around:
- Stimulus: rr_ptr=5, req_valid=6'b100011.
- Response: port1=req5, port2=req0, port3=req1, wb_valid4=0; rr_ptr becomes 2.
REQ-025 Case 4 -- stall then flush:
- Stimulus: wb_stall=1 with req_valid=6'b001111, then flush=1 together with wb_stall=1.
- Response: req_ready=0 in both cycles; wb_valid1..4=0; rr_ptr held during the stall, then 0 after the flush.
REQ-026 Case 5 -- reset mid-transfer:
- Stimulus: assert reset_n=0 between clock edges while wb_valid1=1.
- Response: wb_valid1 drops immediately without waiting for an edge; after release, the first grant starts from index 0.
REQ-027 Case 6 -- statistics (WB_ARB_STATS_EN defined):
- Stimulus: req_valid=6'b111111 for 70000 cycles.
- Response: stat_denied saturates at 16'hFFFF and holds.
